// File: rtl/azadi_pinmux_pkg.sv
// Shared constants and register decode for the Azadi IO pad multiplexer.
package azadi_pinmux_pkg;

  localparam int SEL_FIELD_W  = 4;
  localparam int PADS_PER_SEL = 8;
  localparam int LOCK_BIT     = 0;

  localparam logic [7:0] SEL_OFF      = 8'h00;
  localparam logic [7:0] LOCK_OFF     = 8'h40;
  localparam logic [7:0] PAD_IN_0_OFF = 8'h44;
  localparam logic [7:0] PAD_IN_1_OFF = 8'h48;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_SEL,
    REG_LOCK,
    REG_PAD_IN_0,
    REG_PAD_IN_1
  } reg_addr_e;

  // Misaligned offsets decode as unmapped so they ack with zero data.
  function automatic reg_addr_e decode_reg(input logic [7:0] off, input int num_sel);
    if (off[1:0] != 2'b00)                     return REG_NONE;
    if (off == LOCK_OFF)                       return REG_LOCK;
    if (off == PAD_IN_0_OFF)                   return REG_PAD_IN_0;
    if (off == PAD_IN_1_OFF)                   return REG_PAD_IN_1;
    if (off >= SEL_OFF && int'(off[7:2]) < num_sel) return REG_SEL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/azadi_pad_sync.sv
// Per-bit flop-chain synchroniser for raw pad inputs; clears to 0 on reset.
module azadi_pad_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d_i;
    for (int s = 1; s < STAGES; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/azadi_io_pinmux.sv
// Wishbone-configured pad multiplexer: select registers with sticky lock,
// registered pad outputs and synchronised pad inputs.
module azadi_io_pinmux
  import azadi_pinmux_pkg::*;
#(
  parameter int          NUM_PADS    = 38,
  parameter int          NUM_FUNCS   = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_PADS*NUM_FUNCS-1:0] fn_out_i,
  input  logic [NUM_PADS*NUM_FUNCS-1:0] fn_oe_i,
  output logic [NUM_PADS-1:0]           pad_in_o,
  input  logic [NUM_PADS-1:0]           io_in,
  output logic [NUM_PADS-1:0]           io_out,
  output logic [NUM_PADS-1:0]           io_oeb
);

  localparam int SEL_W   = (NUM_FUNCS > 1) ? $clog2(NUM_FUNCS) : 1;
  localparam int NUM_SEL = (NUM_PADS + PADS_PER_SEL - 1) / PADS_PER_SEL;

  logic [NUM_PADS*SEL_W-1:0] sel_q, sel_d;
  logic                      lock_q, lock_d;
  logic                      ack_q, ack_d;
  logic [31:0]               dat_q, dat_d;
  logic [NUM_PADS-1:0]       io_out_q, io_out_d;
  logic [NUM_PADS-1:0]       io_oeb_q, io_oeb_d;

  logic        hit, acc, wr;
  reg_addr_e   reg_sel;
  logic [5:0]  word_idx;
  logic [31:0] rdata;
  logic [63:0] pad_ext;

  azadi_pad_sync #(.WIDTH(NUM_PADS), .STAGES(SYNC_STAGES)) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d_i (io_in),
    .q_o (pad_in_o)
  );

  // An access is taken only when no ack went out last cycle, giving 2-cycle minimum.
  assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc      = hit & ~ack_q;
  assign wr       = acc & wbs_we_i;
  assign reg_sel  = decode_reg(wbs_adr_i[7:0], NUM_SEL);
  assign word_idx = wbs_adr_i[7:2];

  always_comb begin
    pad_ext               = '0;
    pad_ext[NUM_PADS-1:0] = pad_in_o;
  end

  always_comb begin
    sel_d  = sel_q;
    lock_d = lock_q;
    if (wr && !lock_q) begin
      if (reg_sel == REG_LOCK && wbs_sel_i[0] && wbs_dat_i[LOCK_BIT]) lock_d = 1'b1;
      if (reg_sel == REG_SEL) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          if (word_idx == 6'(p / PADS_PER_SEL) && wbs_sel_i[(p % PADS_PER_SEL) / 2]) begin
            sel_d[p*SEL_W +: SEL_W] = wbs_dat_i[(p % PADS_PER_SEL)*SEL_FIELD_W +: SEL_W];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_SEL: begin
        for (int p = 0; p < NUM_PADS; p++) begin
          if (word_idx == 6'(p / PADS_PER_SEL)) begin
            rdata[(p % PADS_PER_SEL)*SEL_FIELD_W +: SEL_W] = sel_q[p*SEL_W +: SEL_W];
          end
        end
      end
      REG_LOCK:     rdata[LOCK_BIT] = lock_q;
      REG_PAD_IN_0: rdata = pad_ext[31:0];
      REG_PAD_IN_1: rdata = pad_ext[63:32];
      default:      rdata = '0;
    endcase
    ack_d = acc;
    dat_d = (acc && !wbs_we_i) ? rdata : '0;
  end

  // Out-of-range selects fall through to the parked default.
  always_comb begin
    io_out_d = '0;
    io_oeb_d = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int f = 0; f < NUM_FUNCS; f++) begin
        if (sel_q[p*SEL_W +: SEL_W] == SEL_W'(f)) begin
          io_out_d[p] = fn_out_i[p*NUM_FUNCS+f];
          io_oeb_d[p] = ~fn_oe_i[p*NUM_FUNCS+f];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sel_q    <= '0;
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      io_out_q <= '0;
      io_oeb_q <= '1;
    end else begin
      sel_q    <= sel_d;
      lock_q   <= lock_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = io_out_q;
  assign io_oeb    = io_oeb_q;

endmodule

// File: tb/tb_azadi_io_pinmux.sv
// Self-checking bench for azadi_io_pinmux with a read-data scoreboard queue.
module tb_azadi_io_pinmux;

  localparam int          NP   = 38;
  localparam int          NF   = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             stb, cyc, we;
  logic [3:0]       sel;
  logic [31:0]      adr, dat_i;
  logic             ack;
  logic [31:0]      dat_o;
  logic [NP*NF-1:0] fn_out, fn_oe;
  logic [NP-1:0]    pad_in, io_in, io_out, io_oeb;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd, exp_v;

  always #5 clk = ~clk;

  azadi_io_pinmux #(.NUM_PADS(NP), .NUM_FUNCS(NF), .SYNC_STAGES(2), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .fn_out_i  (fn_out),
    .fn_oe_i   (fn_oe),
    .pad_in_o  (pad_in),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // One Wishbone access with a bounded wait for ack; returns the data seen with ack.
  task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rdo);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | {24'h0, off}; dat_i = wd; sel = be;
    rdo = 32'hDEAD_BEEF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL wb_ack_timeout off=%h ack=%b required 1", off, ack);
    end else begin
      rdo = dat_o;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (io_oeb !== 38'h3F_FFFF_FFFF) begin
      errors++; $display("FAIL reset_io_oeb got %h required %h", io_oeb, 38'h3F_FFFF_FFFF);
    end
    checks++;
    if (io_out !== '0 || pad_in !== '0 || ack !== 1'b0 || dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got out=%h pad_in=%h ack=%b dat=%h required 0", io_out, pad_in, ack, dat_o);
    end
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++; $display("FAIL reset_sel0_read got %h required %h", rd, exp_v);
    end
  endtask

  task automatic test_mux();
    // pad0 func0 drives 1, pad1 func1 is a decoy, pad1 func2 is the target, pad2 func0 drives 0
    fn_out = '0; fn_oe = '0;
    fn_out[0] = 1'b1; fn_oe[0] = 1'b1;
    fn_out[5] = 1'b1; fn_oe[5] = 1'b1;
    fn_out[6] = 1'b1; fn_oe[6] = 1'b1;
    fn_oe[8]  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (io_out !== 38'h1 || io_oeb !== 38'h3F_FFFF_FFFA) begin
      errors++; $display("FAIL mux_func0 got out=%h oeb=%h required out=1 oeb=3ffffffffa", io_out, io_oeb);
    end
    wb_xfer(1'b1, 8'h00, 32'h0000_0020, 4'hF, rd);
    checks++;
    if (io_out[1] !== 1'b0 || io_oeb[1] !== 1'b1) begin
      errors++; $display("FAIL mux_latency_ack got out1=%b oeb1=%b required 0 1", io_out[1], io_oeb[1]);
    end
    @(negedge clk);
    checks++;
    if (io_out !== 38'h3 || io_oeb !== 38'h3F_FFFF_FFF8) begin
      errors++; $display("FAIL mux_func2 got out=%h oeb=%h required out=3 oeb=3ffffffff8", io_out, io_oeb);
    end
    fn_out[6] = 1'b0;
    @(negedge clk);
    checks++;
    if (io_out[1] !== 1'b0) begin
      errors++; $display("FAIL mux_follow got %b required 0", io_out[1]);
    end
    fn_out[6] = 1'b1;
    exp_q.push_back(32'h0000_0020);
    wb_xfer(1'b0, 8'h00, 32'h0, 4'hF, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++; $display("FAIL mux_sel0_read got %h required %h", rd, exp_v);
    end
  endtask

  task automatic test_byte_lanes();
    logic [7:0] offs[3];
    wb_xfer(1'b1, 8'h04, 32'hFFFF_FFFF, 4'b0010, rd);
    wb_xfer(1'b1, 8'h10, 32'hFFFF_FFFF, 4'b1111, rd);
    offs[0] = 8'h04; exp_q.push_back(32'h0000_3300);
    offs[1] = 8'h10; exp_q.push_back(32'h0033_3333);
    offs[2] = 8'h08; exp_q.push_back(32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      wb_xfer(1'b0, offs[i], 32'h0, 4'hF, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++; $display("FAIL lanes_read off=%h got %h required %h", offs[i], rd, exp_v);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] offs[3];
    wb_xfer(1'b1, 8'h40, 32'h1, 4'hF, rd);
    wb_xfer(1'b1, 8'h00, 32'h3333_3333, 4'hF, rd);
    wb_xfer(1'b1, 8'h40, 32'h0, 4'hF, rd);
    offs[0] = 8'h00; exp_q.push_back(32'h0000_0020);
    offs[1] = 8'h40; exp_q.push_back(32'h0000_0001);
    offs[2] = 8'h04; exp_q.push_back(32'h0000_3300);
    for (int i = 0; i < 3; i++) begin
      wb_xfer(1'b0, offs[i], 32'h0, 4'hF, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++; $display("FAIL lock_read off=%h got %h required %h", offs[i], rd, exp_v);
      end
    end
    do_reset();
    offs[0] = 8'h40; exp_q.push_back(32'h0);
    offs[1] = 8'h00; exp_q.push_back(32'h0);
    offs[2] = 8'h10; exp_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      wb_xfer(1'b0, offs[i], 32'h0, 4'hF, rd);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin
        errors++; $display("FAIL lock_after_reset off=%h got %h required %h", offs[i], rd, exp_v);
      end
    end
  endtask

  task automatic test_sync();
    @(negedge clk);
    io_in = 38'h20_0000_0001;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (pad_in[37] !== (i >= 2)) begin
        errors++; $display("FAIL sync_rise cycle=%0d got %b required %b", i, pad_in[37], (i >= 2));
      end
    end
    wb_xfer(1'b1, 8'h44, 32'hFFFF_FFFF, 4'hF, rd);
    exp_q.push_back(32'h0000_0020);
    wb_xfer(1'b0, 8'h48, 32'h0, 4'hF, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++; $display("FAIL sync_pad_in_1 got %h required %h", rd, exp_v);
    end
    exp_q.push_back(32'h0000_0001);
    wb_xfer(1'b0, 8'h44, 32'h0, 4'hF, rd);
    exp_v = exp_q.pop_front();
    checks++;
    if (rd !== exp_v) begin
      errors++; $display("FAIL sync_pad_in_0 got %h required %h", rd, exp_v);
    end
    @(negedge clk);
    io_in = '0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (pad_in[37] !== (i < 2)) begin
        errors++; $display("FAIL sync_fall cycle=%0d got %b required %b", i, pad_in[37], (i < 2));
      end
    end
  endtask

  task automatic test_protocol();
    logic [3:0] ack_seen;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h80; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      ack_seen[i] = ack;
      checks++;
      if (dat_o !== 32'h0) begin
        errors++; $display("FAIL proto_unmapped_data cycle=%0d got %h required 0", i, dat_o);
      end
    end
    checks++;
    if (ack_seen !== 4'b1010) begin
      errors++; $display("FAIL proto_ack_pattern got %b required 1010 (cycle0 in lsb)", ack_seen);
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; adr = 32'h3000_0100;
    ack_seen = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ack_seen[i] = ack;
    end
    checks++;
    if (ack_seen !== 4'b0000) begin
      errors++; $display("FAIL proto_miss_no_ack got %b required 0000", ack_seen);
    end
    stb = 1'b0; cyc = 1'b0;
    // reset lands on the hit edge: the ack is dropped, the held request is then served
    wb_xfer(1'b1, 8'h00, 32'h0000_0003, 4'hF, rd);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("FAIL proto_reset_drop got ack=%b required 0", ack);
    end
    rst = 1'b0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++;
    if (ack !== 1'b1 || dat_o !== exp_v) begin
      errors++; $display("FAIL proto_retry got ack=%b dat=%h required 1 %h", ack, dat_o, exp_v);
    end
    stb = 1'b0; cyc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; dat_i = '0; fn_out = '0; fn_oe = '0; io_in = '0;
    test_reset();
    test_mux();
    test_byte_lanes();
    test_lock();
    test_sync();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required finish before 200000", $time);
    $fatal(1);
  end

endmodule
